// File: rtl/regfile_wb_arbiter.sv
// Two-requester register-file writeback arbiter, one single-entry buffer per requester; round-robin on conflict.
// Latency: accept at edge N, wr_en in cycle N+1 when winning; ready_x = buffer empty or draining this cycle.
module regfile_wb_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_a,
    input  logic [3:0]  rd_a,
    input  logic [15:0] data_a,
    output logic        ready_a,
    input  logic        valid_b,
    input  logic [3:0]  rd_b,
    input  logic [15:0] data_b,
    output logic        ready_b,
    output logic [15:0] wr_en,
    output logic [15:0] wr_data,
    output logic [15:0] pending,
    output logic        last_gnt
);

    logic        buf_vld_a_q, buf_vld_a_d;
    logic [3:0]  buf_rd_a_q,  buf_rd_a_d;
    logic [15:0] buf_dat_a_q, buf_dat_a_d;
    logic        buf_vld_b_q, buf_vld_b_d;
    logic [3:0]  buf_rd_b_q,  buf_rd_b_d;
    logic [15:0] buf_dat_b_q, buf_dat_b_d;
    logic        last_gnt_q,  last_gnt_d;

    logic commit_a, commit_b;
    logic acc_a, acc_b;

    always_comb begin
        // On conflict the requester that did not win last time goes first.
        commit_a = buf_vld_a_q & (~buf_vld_b_q | last_gnt_q);
        commit_b = buf_vld_b_q & (~buf_vld_a_q | ~last_gnt_q);

        ready_a = rst & (~buf_vld_a_q | commit_a);
        ready_b = rst & (~buf_vld_b_q | commit_b);
        acc_a   = valid_a & ready_a;
        acc_b   = valid_b & ready_b;

        buf_vld_a_d = buf_vld_a_q & ~commit_a;
        buf_rd_a_d  = buf_rd_a_q;
        buf_dat_a_d = buf_dat_a_q;
        if (acc_a) begin
            buf_vld_a_d = (rd_a != 4'd0);
            buf_rd_a_d  = rd_a;
            buf_dat_a_d = data_a;
        end

        buf_vld_b_d = buf_vld_b_q & ~commit_b;
        buf_rd_b_d  = buf_rd_b_q;
        buf_dat_b_d = buf_dat_b_q;
        if (acc_b) begin
            buf_vld_b_d = (rd_b != 4'd0);
            buf_rd_b_d  = rd_b;
            buf_dat_b_d = data_b;
        end

        last_gnt_d = last_gnt_q;
        if (commit_a)      last_gnt_d = 1'b0;
        else if (commit_b) last_gnt_d = 1'b1;

        wr_en   = '0;
        wr_data = '0;
        if (commit_a) begin
            wr_en[buf_rd_a_q] = 1'b1;
            wr_data           = buf_dat_a_q;
        end else if (commit_b) begin
            wr_en[buf_rd_b_q] = 1'b1;
            wr_data           = buf_dat_b_q;
        end

        pending = '0;
        for (int r = 1; r < 16; r++) begin
            pending[r] = (buf_vld_a_q && (buf_rd_a_q == 4'(r)))
                       | (buf_vld_b_q && (buf_rd_b_q == 4'(r)));
        end
    end

    assign last_gnt = last_gnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_vld_a_q <= 1'b0;
            buf_rd_a_q  <= '0;
            buf_dat_a_q <= '0;
            buf_vld_b_q <= 1'b0;
            buf_rd_b_q  <= '0;
            buf_dat_b_q <= '0;
            last_gnt_q  <= 1'b1;
        end else begin
            buf_vld_a_q <= buf_vld_a_d;
            buf_rd_a_q  <= buf_rd_a_d;
            buf_dat_a_q <= buf_dat_a_d;
            buf_vld_b_q <= buf_vld_b_d;
            buf_rd_b_q  <= buf_rd_b_d;
            buf_dat_b_q <= buf_dat_b_d;
            last_gnt_q  <= last_gnt_d;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: inputs driven 1 time unit after the rising edge, outputs checked on the falling edge.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        valid_a, valid_b;
    logic [3:0]  rd_a, rd_b;
    logic [15:0] data_a, data_b;
    logic        ready_a, ready_b;
    logic [15:0] wr_en, wr_data, pending;
    logic        last_gnt;

    int checks   = 0;
    int failures = 0;

    logic [15:0] regs [16] = '{default: 16'h0};

    regfile_wb_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .valid_a  (valid_a),
        .rd_a     (rd_a),
        .data_a   (data_a),
        .ready_a  (ready_a),
        .valid_b  (valid_b),
        .rd_b     (rd_b),
        .data_b   (data_b),
        .ready_b  (ready_b),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .pending  (pending),
        .last_gnt (last_gnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Register-file model driven by the arbiter's write port.
    always @(posedge clk) begin
        for (int r = 0; r < 16; r++)
            if (wr_en[r]) regs[r] <= wr_data;
    end

    // At most one enable, never register 0.
    always @(negedge clk) begin
        if (rst) check("wr_en_legal", {30'd0, wr_en[0], $onehot0(wr_en)}, 32'd1);
    end

    initial begin
        rst = 1'b0;
        valid_a = 1'b0; rd_a = '0; data_a = '0;
        valid_b = 1'b0; rd_b = '0; data_b = '0;

        // Reset state
        @(negedge clk);
        check("rst_wr_en", wr_en, 16'h0000);
        check("rst_wr_data", wr_data, 16'h0000);
        check("rst_pending", pending, 16'h0000);
        check("rst_ready_a", ready_a, 1'b0);
        check("rst_ready_b", ready_b, 1'b0);
        check("rst_last_gnt", last_gnt, 1'b1);
        step;
        rst = 1'b1;
        @(negedge clk);
        check("rel_ready_a", ready_a, 1'b1);
        check("rel_ready_b", ready_b, 1'b1);

        // Conflict after reset: A first, then B
        step;
        valid_a = 1'b1; rd_a = 4'd3; data_a = 16'hAAAA;
        valid_b = 1'b1; rd_b = 4'd7; data_b = 16'h5555;
        @(negedge clk);
        check("cf_c0_ready_a", ready_a, 1'b1);
        check("cf_c0_ready_b", ready_b, 1'b1);
        step;
        valid_a = 1'b0; valid_b = 1'b0;
        @(negedge clk);
        check("cf_c1_wr_en", wr_en, 16'h0008);
        check("cf_c1_wr_data", wr_data, 16'hAAAA);
        check("cf_c1_pending", pending, 16'h0088);
        check("cf_c1_ready_b", ready_b, 1'b0);
        step;
        @(negedge clk);
        check("cf_c2_wr_en", wr_en, 16'h0080);
        check("cf_c2_wr_data", wr_data, 16'h5555);
        step;
        @(negedge clk);
        check("cf_c3_wr_en", wr_en, 16'h0000);
        check("cf_c3_pending", pending, 16'h0000);
        check("cf_last_gnt", last_gnt, 1'b1);
        check("cf_reg3", regs[3], 16'hAAAA);
        check("cf_reg7", regs[7], 16'h5555);

        // Single write
        step;
        valid_a = 1'b1; rd_a = 4'd5; data_a = 16'h1234;
        @(negedge clk);
        check("sw_c0_ready_a", ready_a, 1'b1);
        step;
        valid_a = 1'b0;
        @(negedge clk);
        check("sw_c1_wr_en", wr_en, 16'h0020);
        check("sw_c1_wr_data", wr_data, 16'h1234);
        check("sw_c1_pending", pending, 16'h0020);
        step;
        @(negedge clk);
        check("sw_c2_pending", pending, 16'h0000);
        check("sw_c2_wr_en", wr_en, 16'h0000);
        check("sw_last_gnt", last_gnt, 1'b0);
        check("sw_reg5", regs[5], 16'h1234);

        // Same destination with last_gnt = 0: B commits first, A last
        step;
        valid_a = 1'b1; rd_a = 4'd9; data_a = 16'h0001;
        valid_b = 1'b1; rd_b = 4'd9; data_b = 16'h0002;
        @(negedge clk);
        step;
        valid_a = 1'b0; valid_b = 1'b0;
        @(negedge clk);
        check("sd_c1_wr_en", wr_en, 16'h0200);
        check("sd_c1_wr_data", wr_data, 16'h0002);
        check("sd_c1_ready_a", ready_a, 1'b0);
        step;
        @(negedge clk);
        check("sd_c2_wr_en", wr_en, 16'h0200);
        check("sd_c2_wr_data", wr_data, 16'h0001);
        step;
        @(negedge clk);
        check("sd_reg9", regs[9], 16'h0001);
        check("sd_last_gnt", last_gnt, 1'b0);

        // Write to R0 is accepted and dropped
        step;
        valid_b = 1'b1; rd_b = 4'd0; data_b = 16'hFFFF;
        @(negedge clk);
        check("r0_ready_b", ready_b, 1'b1);
        step;
        valid_b = 1'b0;
        @(negedge clk);
        check("r0_wr_en", wr_en, 16'h0000);
        check("r0_pending", pending, 16'h0000);
        check("r0_last_gnt", last_gnt, 1'b0);

        // Round-robin: both offer for cycles 0..8, then drain
        for (int k = 0; k <= 11; k++) begin
            step;
            valid_a = (k <= 8); rd_a = 4'd2;  data_a = 16'h0A0A;
            valid_b = (k <= 8); rd_b = 4'd11; data_b = 16'h0B0B;
            @(negedge clk);
            if (k == 0) begin
                check("rr_c0_wr_en", wr_en, 16'h0000);
                check("rr_c0_ready_ab", {ready_a, ready_b}, 2'b11);
            end else if (k <= 10) begin
                check($sformatf("rr_wr_en_%0d", k), wr_en, (k % 2 == 1) ? 16'h0800 : 16'h0004);
                check($sformatf("rr_wr_data_%0d", k), wr_data, (k % 2 == 1) ? 16'h0B0B : 16'h0A0A);
                if (k <= 9)
                    check($sformatf("rr_ready_%0d", k), {ready_a, ready_b}, (k % 2 == 1) ? 2'b01 : 2'b10);
            end else begin
                check("rr_idle_wr_en", wr_en, 16'h0000);
                check("rr_idle_pending", pending, 16'h0000);
            end
        end
        valid_a = 1'b0; valid_b = 1'b0;

        // Reset mid-operation with both buffers full
        step;
        valid_a = 1'b1; rd_a = 4'd4; data_a = 16'h4444;
        valid_b = 1'b1; rd_b = 4'd6; data_b = 16'h6666;
        step;
        valid_a = 1'b0; valid_b = 1'b0;
        @(negedge clk);
        check("rm_full_pending", pending, 16'h0050);
        check("rm_full_wr_en", wr_en, 16'h0040);
        rst = 1'b0;
        #1;
        check("rm_wr_en", wr_en, 16'h0000);
        check("rm_pending", pending, 16'h0000);
        check("rm_ready_ab", {ready_a, ready_b}, 2'b00);
        check("rm_last_gnt", last_gnt, 1'b1);
        step;
        step;
        rst = 1'b1;
        @(negedge clk);
        check("rm_rel_wr_en", wr_en, 16'h0000);
        check("rm_rel_ready_ab", {ready_a, ready_b}, 2'b11);
        step;
        @(negedge clk);
        check("rm_nostale_wr_en", wr_en, 16'h0000);
        check("rm_reg4", regs[4], 16'h0000);
        check("rm_reg6", regs[6], 16'h0000);

        step;
        valid_a = 1'b1; rd_a = 4'd5; data_a = 16'h5A5A;
        @(negedge clk);
        check("pr_c0_ready_a", ready_a, 1'b1);
        step;
        valid_a = 1'b0;
        @(negedge clk);
        check("pr_c1_wr_en", wr_en, 16'h0020);
        check("pr_c1_wr_data", wr_data, 16'h5A5A);
        check("pr_c1_pending", pending, 16'h0020);
        step;
        @(negedge clk);
        check("pr_c2_pending", pending, 16'h0000);
        check("pr_reg5", regs[5], 16'h5A5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
